pipeline_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline.
- Each cycle it computes the PC enable and the per-register control state (ENABLE/STALL/NOP) for the F/D, D/E, E/M and M/W pipeline registers.
- Inputs are instruction/data memory handshakes, load-use hazards, taken branches and halt.
- A small FSM tracks outstanding data-memory accesses and halt, so an access is never issued twice and a halted core stays frozen.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/hazard_detect.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module  : cpu_types_pkg
// Brief   : Shared pipeline control and hazard sequencer types.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_NOP    = 2'd2
  } pipe_state_t;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_DWAIT  = 2'd1,
    HZ_DDONE  = 2'd2,
    HZ_HALTED = 2'd3
  } hazard_fsm_t;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module  : hazard_detect
// Brief   : Load-use compare between the EX-stage load and DEC-stage sources.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             e_dREN,
  input  logic [REG_W-1:0] e_rt,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic             d_uses_rt,
  output logic             lu
);

  // Register 0 is hard-wired, so a load into it never creates a dependency.
  assign lu = e_dREN && (e_rt != '0) &&
              ((e_rt == d_rs) || (d_uses_rt && (e_rt == d_rt)));

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : PC enable and F/D, D/E, E/M, M/W register control for the 5-stage
//           pipeline. PIPE_PERF_CNT_EN adds saturating stall/flush counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             m_dREN,
  input  logic             m_dWEN,
  input  logic             e_dREN,
  input  logic [REG_W-1:0] e_rt,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic             d_uses_rt,
  input  logic             e_branch_taken,
  input  logic             w_halt,
  output logic             pc_en,
  output pipe_state_t      fd_state,
  output pipe_state_t      de_state,
  output pipe_state_t      em_state,
  output pipe_state_t      mw_state,
  output logic             dmem_mask,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_fsm_t state_q, state_d;
  logic        lu;
  logic        fe_pc_en;
  pipe_state_t fe_fd, fe_de, fe_em, fe_mw;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .e_dREN    (e_dREN),
    .e_rt      (e_rt),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_uses_rt (d_uses_rt),
    .lu        (lu)
  );

  // Front-end resolution used whenever the memory side is not holding the pipe.
  always_comb begin
    fe_pc_en = 1'b1;
    fe_fd    = PIPE_ENABLE;
    fe_de    = PIPE_ENABLE;
    fe_em    = PIPE_ENABLE;
    fe_mw    = PIPE_ENABLE;
    if (e_branch_taken) begin
      if (ihit) begin
        fe_fd = PIPE_NOP;
        fe_de = PIPE_NOP;
      end else begin
        fe_pc_en = 1'b0;
        fe_fd    = PIPE_STALL;
        fe_de    = PIPE_STALL;
        fe_em    = PIPE_NOP;
      end
    end else if (lu) begin
      fe_pc_en = 1'b0;
      fe_fd    = PIPE_STALL;
      fe_de    = PIPE_NOP;
    end else if (!ihit) begin
      fe_pc_en = 1'b0;
      fe_fd    = PIPE_NOP;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= HZ_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pc_en     = 1'b0;
    fd_state  = PIPE_STALL;
    de_state  = PIPE_STALL;
    em_state  = PIPE_STALL;
    mw_state  = PIPE_STALL;
    dmem_mask = 1'b0;
    halted    = 1'b0;
    if (RST) begin
      state_d = HZ_RUN;
    end else if (w_halt || (state_q == HZ_HALTED)) begin
      state_d   = HZ_HALTED;
      dmem_mask = 1'b1;
      halted    = 1'b1;
    end else begin
      case (state_q)
        HZ_RUN: begin
          // The mask is never set in RUN, so any request here is a live dreq.
          if ((m_dREN || m_dWEN) && !dhit) begin
            mw_state = PIPE_NOP;
            state_d  = HZ_DWAIT;
          end else begin
            pc_en    = fe_pc_en;
            fd_state = fe_fd;
            de_state = fe_de;
            em_state = fe_em;
            mw_state = fe_mw;
          end
        end
        HZ_DWAIT: begin
          if (!dhit) begin
            mw_state = PIPE_NOP;
          end else if (ihit) begin
            pc_en    = fe_pc_en;
            fd_state = fe_fd;
            de_state = fe_de;
            em_state = fe_em;
            mw_state = fe_mw;
            state_d  = HZ_RUN;
          end else begin
            mw_state = PIPE_ENABLE;
            state_d  = HZ_DDONE;
          end
        end
        HZ_DDONE: begin
          // Data access already retired; mask keeps the cache from seeing it again.
          dmem_mask = 1'b1;
          if (ihit) begin
            pc_en    = 1'b1;
            fd_state = PIPE_ENABLE;
            de_state = PIPE_ENABLE;
            em_state = PIPE_ENABLE;
            mw_state = PIPE_ENABLE;
            state_d  = HZ_RUN;
          end else begin
            mw_state = PIPE_NOP;
          end
        end
        default: begin
          state_d = HZ_HALTED;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             flush_ev;

  // Only the taken-branch-with-ihit case produces this output pattern.
  assign flush_ev = pc_en && (fd_state == PIPE_NOP) && (de_state == PIPE_NOP);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!halted && !pc_en && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_ev && !(&flush_cnt_q))          flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Scoreboard bench for pipeline_hazard_ctrl (honours PIPE_PERF_CNT_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;
  import cpu_types_pkg::*;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;
  localparam pipe_state_t E = PIPE_ENABLE;
  localparam pipe_state_t S = PIPE_STALL;
  localparam pipe_state_t N = PIPE_NOP;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             ihit = 1'b0, dhit = 1'b0, m_dREN = 1'b0, m_dWEN = 1'b0;
  logic             e_dREN = 1'b0, d_uses_rt = 1'b0, e_branch_taken = 1'b0, w_halt = 1'b0;
  logic [REG_W-1:0] e_rt = '0, d_rs = '0, d_rt = '0;
  logic             pc_en, dmem_mask, halted;
  pipe_state_t      fd_state, de_state, em_state, mw_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .m_dREN(m_dREN), .m_dWEN(m_dWEN),
    .e_dREN(e_dREN), .e_rt(e_rt), .d_rs(d_rs), .d_rt(d_rt), .d_uses_rt(d_uses_rt),
    .e_branch_taken(e_branch_taken), .w_halt(w_halt), .pc_en(pc_en),
    .fd_state(fd_state), .de_state(de_state), .em_state(em_state), .mw_state(mw_state),
    .dmem_mask(dmem_mask), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int               id;
    logic             pc;
    pipe_state_t      fd, de, em, mw;
    logic             mask, hl;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;

  exp_t             sb[$];
  int               n_vec = 0;
  int               n_bad = 0;
  int               n_id  = 0;
  logic [CNT_W-1:0] m_sc = '0, m_fc = '0;

  task automatic d(input logic r, ih, dh, mr, mwe, er, input logic [REG_W-1:0] ert, drs, drt,
                   input logic urt, bt, wh);
    @(posedge CLK);
    #1;
    RST = r; ihit = ih; dhit = dh; m_dREN = mr; m_dWEN = mwe; e_dREN = er;
    e_rt = ert; d_rs = drs; d_rt = drt; d_uses_rt = urt; e_branch_taken = bt; w_halt = wh;
  endtask

  task automatic x(input logic pc, input pipe_state_t fd, de, em, mw, input logic mask, hl);
    exp_t e;
    if (RST) begin
      m_sc = '0;
      m_fc = '0;
    end
    e.id = n_id; e.pc = pc; e.fd = fd; e.de = de; e.em = em; e.mw = mw;
    e.mask = mask; e.hl = hl;
`ifdef PIPE_PERF_CNT_EN
    e.sc = m_sc; e.fc = m_fc;
    if (!RST) begin
      if (!hl && !pc && (m_sc != '1)) m_sc = m_sc + 1'b1;
      if (pc && fd == N && de == N && (m_fc != '1)) m_fc = m_fc + 1'b1;
    end
`else
    e.sc = '0; e.fc = '0;
`endif
    sb.push_back(e);
    n_id++;
  endtask

  // Monitor: outputs are combinational, so every cycle with a queued entry is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (pc_en !== e.pc || fd_state !== e.fd || de_state !== e.de || em_state !== e.em ||
            mw_state !== e.mw || dmem_mask !== e.mask || halted !== e.hl ||
            stall_cnt !== e.sc || flush_cnt !== e.fc) begin
          n_bad++;
          $display("FAIL vec%0d: got pc=%0d fd=%0d de=%0d em=%0d mw=%0d mask=%0d halt=%0d sc=%0d fc=%0d | exp pc=%0d fd=%0d de=%0d em=%0d mw=%0d mask=%0d halt=%0d sc=%0d fc=%0d",
                   e.id, pc_en, fd_state, de_state, em_state, mw_state, dmem_mask, halted,
                   stall_cnt, flush_cnt, e.pc, e.fd, e.de, e.em, e.mw, e.mask, e.hl, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    //  r ih dh mr mw er ert drs drt urt bt wh
    d(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x(0, S, S, S, S, 0, 0);  // reset
    d(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x(1, E, E, E, E, 0, 0);
    d(0, 1, 0, 0, 0, 1, 8, 8, 0, 0, 0, 0); x(0, S, N, E, E, 0, 0);  // load-use rs
    d(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x(1, E, E, E, E, 0, 0);
    d(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); x(1, E, E, E, E, 0, 0);  // e_rt = 0
    d(0, 1, 0, 0, 0, 1, 5, 3, 5, 1, 0, 0); x(0, S, N, E, E, 0, 0);  // load-use rt
    d(0, 1, 0, 0, 0, 1, 5, 3, 5, 0, 0, 0); x(1, E, E, E, E, 0, 0);  // rt not read
    d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x(0, N, E, E, E, 0, 0);  // ifetch miss
    d(0, 0, 0, 0, 0, 1, 8, 8, 0, 0, 0, 0); x(0, S, N, E, E, 0, 0);  // lu without ihit
    for (int i = 0; i < 3; i++) begin
      d(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); x(0, S, S, S, N, 0, 0); // dmem miss
    end
    d(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); x(1, E, E, E, E, 0, 0);
    d(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x(1, E, E, E, E, 0, 0);  // back in RUN
    d(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); x(0, S, S, S, N, 0, 0);  // store miss
    d(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0); x(0, S, S, S, E, 0, 0);  // dhit, no ihit
    for (int i = 0; i < 2; i++) begin
      d(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); x(0, S, S, S, N, 1, 0); // DDONE
    end
    d(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); x(1, E, E, E, E, 1, 0);
    d(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x(1, E, E, E, E, 0, 0);
    d(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); x(1, N, N, E, E, 0, 0);  // branch flush
    d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); x(0, S, S, N, E, 0, 0);  // branch, no ihit
    d(0, 1, 0, 0, 0, 1, 8, 8, 0, 0, 1, 0); x(1, N, N, E, E, 0, 0);  // branch beats lu
    d(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); x(0, S, S, S, N, 0, 0);
    d(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0); x(1, N, N, E, E, 0, 0);  // DWAIT exit + branch
    d(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); x(0, S, S, S, N, 0, 0);
    d(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1); x(0, S, S, S, S, 1, 1);  // halt in DWAIT
    d(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x(0, S, S, S, S, 1, 1);
    d(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0); x(0, S, S, S, S, 1, 1);
    d(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x(0, S, S, S, S, 0, 0);  // reset
    d(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x(1, E, E, E, E, 0, 0);
    d(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); x(0, S, S, S, N, 0, 0);
    d(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); x(0, S, S, S, S, 0, 0);  // reset in DWAIT
    d(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x(1, E, E, E, E, 0, 0);
    d(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); x(0, S, S, S, N, 0, 0);
    d(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1); x(0, S, S, S, S, 1, 1);  // dhit + halt
    d(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x(0, S, S, S, S, 1, 1);
    d(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x(0, S, S, S, S, 0, 0);
    d(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x(1, E, E, E, E, 0, 0);
    repeat (3) @(posedge CLK);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
